// File: rtl/pipe_adder_pkg.sv
// Shared arithmetic defaults for the segmented pipelined adder.
// Operand width and per-stage segment width live here.
package pipe_adder_pkg;

  localparam int PA_WIDTH = 16;
  localparam int PA_SEG   = 4;

  function automatic logic ovf_of(
    input logic am,
    input logic bm,
    input logic sm
  );
    return (am == bm) && (sm != am);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One SEG-bit registered add stage with carry in/out.
// Holds its result and carry while the enable is low.
module adder_slice #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0]   w_add;
  logic [W-1:0] r_sum;
  logic         r_cout;

  assign w_add = {1'b0, i_a} + {1'b0, i_b}
               + {{W{1'b0}}, i_cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (i_en) begin
      r_sum  <= w_add[W-1:0];
      r_cout <= w_add[W];
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: rtl/pipe_adder.sv
// Segmented pipelined add/sub with valid/ready flow control.
// Stage k adds slice k; operands are skewed in, results deskewed out.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = PA_WIDTH,
  parameter int SEG   = PA_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  if ((WIDTH % SEG) != 0 || WIDTH < SEG) begin : g_chk
    $error("pipe_adder: WIDTH must be a nonzero multiple of SEG");
  end

  logic                         w_en;
  logic [WIDTH-1:0]             w_beff;
  logic                         w_ceff;
  logic [STAGES-1:0]            r_v;
  logic [STAGES-1:0][SEG-1:0]   w_sa;
  logic [STAGES-1:0][SEG-1:0]   w_sb;
  logic [STAGES-1:0][SEG-1:0]   w_sl;
  logic [STAGES-1:0][SEG-1:0]   w_so;
  logic [STAGES:0]              w_c;
  logic                         r_amsb;
  logic                         r_bmsb;

  // One global enable freezes the whole pipe on a stalled output.
  assign w_en      = !r_v[STAGES-1] | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v[STAGES-1];

  assign w_beff = sub ? ~b : b;
  assign w_ceff = sub ? ~cin : cin;
  assign w_c[0] = w_ceff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else if (w_en) begin
      r_v <= (r_v << 1) | STAGES'(in_valid);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int D = STAGES - 1 - k;

    if (k == 0) begin : g_nosk
      assign w_sa[k] = a[SEG-1:0];
      assign w_sb[k] = w_beff[SEG-1:0];
    end else begin : g_sk
      logic [SEG-1:0] r_ad [k];
      logic [SEG-1:0] r_bd [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < k; d++) begin
            r_ad[d] <= '0;
            r_bd[d] <= '0;
          end
        end else if (w_en) begin
          r_ad[0] <= a[k*SEG +: SEG];
          r_bd[0] <= w_beff[k*SEG +: SEG];
          for (int d = 1; d < k; d++) begin
            r_ad[d] <= r_ad[d-1];
            r_bd[d] <= r_bd[d-1];
          end
        end
      end

      assign w_sa[k] = r_ad[k-1];
      assign w_sb[k] = r_bd[k-1];
    end

    adder_slice #(
      .W(SEG)
    ) u_slice (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_en),
      .i_a    (w_sa[k]),
      .i_b    (w_sb[k]),
      .i_cin  (w_c[k]),
      .o_sum  (w_sl[k]),
      .o_cout (w_c[k+1])
    );

    if (D == 0) begin : g_nods
      assign w_so[k] = w_sl[k];
    end else begin : g_ds
      logic [SEG-1:0] r_sd [D];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < D; d++) begin
            r_sd[d] <= '0;
          end
        end else if (w_en) begin
          r_sd[0] <= w_sl[k];
          for (int d = 1; d < D; d++) begin
            r_sd[d] <= r_sd[d-1];
          end
        end
      end

      assign w_so[k] = r_sd[D-1];
    end
  end

  // Operand sign bits travel with the top slice for overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
    end else if (w_en) begin
      r_amsb <= w_sa[STAGES-1][SEG-1];
      r_bmsb <= w_sb[STAGES-1][SEG-1];
    end
  end

  assign sum  = w_so;
  assign cout = w_c[STAGES];
  assign ovf  = ovf_of(r_amsb, r_bmsb, sum[WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder at 16/4, 4/4 and 8/2.
module tb_pipe_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res16_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid, out_ready, cin, sub;
  logic [15:0] a, b;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] sum;

  logic       in_valid4, out_ready4, cin4, sub4;
  logic [3:0] a4, b4;
  logic       in_ready4, out_valid4, cout4, ovf4;
  logic [3:0] sum4;

  logic       in_valid8, out_ready8, cin8, sub8;
  logic [7:0] a8, b8;
  logic       in_ready8, out_valid8, cout8, ovf8;
  logic [7:0] sum8;

  int n_pass = 0;
  int n_total = 0;

  res16_t exp_q[$];
  logic   hold_v = 1'b0;
  res16_t hold_r;

  always #5 clk = ~clk;

  pipe_adder u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_adder #(.WIDTH(4), .SEG(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  pipe_adder #(.WIDTH(8), .SEG(2)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  function automatic res16_t model16(
    input logic [15:0] x, input logic [15:0] y,
    input logic ci, input logic sb
  );
    logic [15:0] be;
    logic [16:0] t;
    res16_t r;
    be = sb ? ~y : y;
    t = {1'b0, x} + {1'b0, be} + {16'd0, (sb ? ~ci : ci)};
    r.s = t[15:0];
    r.c = t[16];
    r.o = (x[15] == be[15]) && (t[15] != x[15]);
    return r;
  endfunction

  function automatic logic [5:0] model4(
    input logic [3:0] x, input logic [3:0] y,
    input logic ci, input logic sb
  );
    logic [3:0] be;
    logic [4:0] t;
    logic o;
    be = sb ? ~y : y;
    t = {1'b0, x} + {1'b0, be} + {4'd0, (sb ? ~ci : ci)};
    o = (x[3] == be[3]) && (t[3] != x[3]);
    return {o, t[4], t[3:0]};
  endfunction

  task automatic step16(
    input logic v, input logic [15:0] ta, input logic [15:0] tb_,
    input logic tc, input logic ts, input logic ordy,
    output logic acc
  );
    res16_t e;
    logic want_rdy;
    @(negedge clk);
    in_valid = v; a = ta; b = tb_; cin = tc; sub = ts;
    out_ready = ordy;
    #1;
    want_rdy = !out_valid || out_ready;
    n_total++;
    if (in_ready !== want_rdy)
      $display("FAIL in_ready: got %b want %b", in_ready, want_rdy);
    else n_pass++;
    if (hold_v) begin
      n_total++;
      if ({sum, cout, ovf} !== hold_r)
        $display("FAIL stall_hold: got %h want %h", {sum, cout, ovf}, hold_r);
      else n_pass++;
    end
    if (out_valid && out_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_out: got sum %h want no output", sum);
      end else begin
        e = exp_q.pop_front();
        if ({sum, cout, ovf} !== e)
          $display("FAIL result: got %h want %h", {sum, cout, ovf}, e);
        else n_pass++;
      end
    end
    hold_v = out_valid && !out_ready;
    hold_r = {sum, cout, ovf};
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model16(ta, tb_, tc, ts));
  endtask

  task automatic drain16();
    logic acc;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++)
      step16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic send_expect(
    input logic [15:0] ta, input logic [15:0] tb_,
    input logic tc, input logic ts,
    input logic [15:0] es, input logic ec, input logic eo,
    input int el, input string nm
  );
    logic acc;
    logic got;
    int lat;
    step16(1'b1, ta, tb_, tc, ts, 1'b1, acc);
    n_total++;
    if (acc !== 1'b1) $display("FAIL %s_accept: got %b want 1", nm, acc);
    else n_pass++;
    lat = 0;
    got = 1'b0;
    while (lat < 12 && !got) begin
      step16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
      lat++;
      got = out_valid;
    end
    n_total++;
    if (!got || lat != el)
      $display("FAIL %s_latency: got %0d want %0d", nm, lat, el);
    else n_pass++;
    n_total++;
    if ({sum, cout, ovf} !== {es, ec, eo})
      $display("FAIL %s_value: got %h want %h", nm, {sum, cout, ovf}, {es, ec, eo});
    else n_pass++;
  endtask

  task automatic test_reset();
    in_valid = 0; out_ready = 1; a = 0; b = 0; cin = 0; sub = 0;
    in_valid4 = 0; out_ready4 = 1; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0;
    in_valid8 = 0; out_ready8 = 1; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    #1;
    n_total++;
    if ({out_valid, sum, cout, ovf} !== 19'd0)
      $display("FAIL reset16: got %h want 0", {out_valid, sum, cout, ovf});
    else n_pass++;
    n_total++;
    if ({out_valid4, out_valid8} !== 2'b00)
      $display("FAIL reset_small: got %b want 00", {out_valid4, out_valid8});
    else n_pass++;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    send_expect(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, "wrap");
    send_expect(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4, "ovf_add");
    send_expect(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4, "sub_neg");
    send_expect(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4, "ovf_sub");
    send_expect(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, 4, "carry_chain");
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra [32];
    logic [15:0] rb [32];
    logic rc [32];
    logic rs [32];
    logic acc;
    logic tog;
    int idx;
    int cyc;
    for (int i = 0; i < 32; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rc[i] = 1'($urandom);
      rs[i] = 1'($urandom);
    end
    idx = 0;
    cyc = 0;
    tog = 1'b1;
    while (idx < 32 && cyc < 200) begin
      step16(1'b1, ra[idx], rb[idx], rc[idx], rs[idx], tog, acc);
      if (acc) idx++;
      tog = ~tog;
      cyc++;
    end
    n_total++;
    if (idx != 32) $display("FAIL stream_accept: got %0d want 32", idx);
    else n_pass++;
    drain16();
  endtask

  task automatic test_reset_mid();
    logic acc;
    for (int i = 0; i < 3; i++)
      step16(1'b1, 16'h1000 + 16'(i), 16'h0100, 1'b0, 1'b0, 1'b1, acc);
    step16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, acc);
    step16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, acc);
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", out_valid);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, sum, cout, ovf} !== 19'd0)
      $display("FAIL mid_reset: got %h want 0", {out_valid, sum, cout, ovf});
    else n_pass++;
    exp_q.delete();
    hold_v = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    send_expect(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 4, "post_reset");
    drain16();
  endtask

  task automatic test_exhaustive4();
    logic [5:0] pe;
    pe = '0;
    out_ready4 = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      in_valid4 = 1'b1;
      {sub4, cin4, b4, a4} = 10'(i);
      #1;
      if (i > 0) begin
        n_total++;
        if ({out_valid4, ovf4, cout4, sum4} !== {1'b1, pe})
          $display("FAIL w4_case%0d: got %h want %h", i - 1,
                   {out_valid4, ovf4, cout4, sum4}, {1'b1, pe});
        else n_pass++;
      end
      pe = model4(a4, b4, cin4, sub4);
    end
    @(negedge clk);
    in_valid4 = 1'b0;
    #1;
    n_total++;
    if ({out_valid4, ovf4, cout4, sum4} !== {1'b1, pe})
      $display("FAIL w4_last: got %h want %h", {out_valid4, ovf4, cout4, sum4}, {1'b1, pe});
    else n_pass++;
  endtask

  task automatic test_w8();
    int lat;
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; sub8 = 1'b0;
    out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_total++;
    if (lat != 4) $display("FAIL w8_latency: got %0d want 4", lat);
    else n_pass++;
    n_total++;
    if ({sum8, cout8, ovf8} !== {8'h01, 1'b1, 1'b0})
      $display("FAIL w8_value: got %h want %h", {sum8, cout8, ovf8}, {8'h01, 1'b1, 1'b0});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive4();
    test_w8();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
